// File: rtl/gate_truth_table_checker_pkg.sv
// Shared types and constants for the two-input gate self-test sequencer.
// Holds FSM state encoding and library truth tables.
package gate_truth_table_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE
  } state_e;

  localparam int NUM_COMBOS = 4;

  localparam logic [NUM_COMBOS-1:0] NOR_TT  = 4'b0001;
  localparam logic [NUM_COMBOS-1:0] NAND_TT = 4'b0111;
  localparam logic [NUM_COMBOS-1:0] AND_TT  = 4'b1000;
  localparam logic [NUM_COMBOS-1:0] OR_TT   = 4'b1110;
  localparam logic [NUM_COMBOS-1:0] XOR_TT  = 4'b0110;

endpackage

// File: rtl/gate_truth_table_checker_settle_timer.sv
// Settle-time up-counter with clear/enable.
// tc_o flags the last settle cycle (count == SETTLE_CYCLES-1).
module gate_truth_table_checker_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam logic [W-1:0] TC = W'(SETTLE_CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC);

endmodule

// File: rtl/gate_truth_table_checker.sv
// Walks a 2-input gate through 00,01,10,11, samples its output
// after a settle time and compares against an expected truth table.
module gate_truth_table_checker
  import gate_truth_table_checker_pkg::*;
#(
  parameter int                     SETTLE_CYCLES = 2,
  parameter logic [NUM_COMBOS-1:0]  EXPECT        = NOR_TT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  DUT_Y,
  output logic                  DUT_A,
  output logic                  DUT_B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS,
  output logic [NUM_COMBOS-1:0] FAIL_MASK,
  output logic [NUM_COMBOS-1:0] CAPTURED
);

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [1:0]            ab_q, ab_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [NUM_COMBOS-1:0] fail_q, fail_d;
  logic [NUM_COMBOS-1:0] cap_q, cap_d;
  logic                  tmr_clr;
  logic                  tmr_en;
  logic                  tmr_tc;

  gate_truth_table_checker_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_o  (tmr_tc)
  );

  // Sequencer next-state, drive and result logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ab_d    = ab_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;
    cap_d   = cap_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ab_d   = 2'b00;
        busy_d = 1'b0;
        if (START) begin
          idx_d   = 2'd0;
          tmr_clr = 1'b1;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          fail_d  = '0;
          cap_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        cap_d[idx_q]  = DUT_Y;
        fail_d[idx_q] = DUT_Y ^ EXPECT[idx_q];
        tmr_clr       = 1'b1;
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          ab_d    = idx_q + 2'd1;
          state_d = ST_SETTLE;
        end else begin
          done_d  = 1'b1;
          pass_d  = (fail_d == '0);
          busy_d  = 1'b0;
          ab_d    = 2'b00;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ab_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      cap_q   <= cap_d;
    end
  end

  assign DUT_A     = ab_q[1];
  assign DUT_B     = ab_q[0];
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign FAIL_MASK = fail_q;
  assign CAPTURED  = cap_q;

endmodule

// File: doc/gate_truth_table_checker.md
Name: gate_truth_table_checker

Overview:
- Self-test sequencer for the two-input gate cells (NOR, NAND, AND, OR, XOR) in the library.
- Drives the DUT inputs A, B through all four combinations (00, 01, 10, 11).
- Waits a programmable settle time after each combination, samples the DUT output and compares it against an expected truth table.
- Reports pass/fail plus a per-combination mismatch mask. It sits directly upstream of the gate under test (driving it) and consumes the gate's output.

Parameters:
- SETTLE_CYCLES, 2: clock cycles between driving a combination and sampling DUT_Y. Must be >= 1; 0 is illegal.
- EXPECT, 4'b0001: expected DUT_Y per combination. Bit i is the expected output for {A,B} = i. The default 4'b0001 is the NOR truth table.

Ports:
- CLK  input  1  single clock; all logic on rising edge
- RST  input  1  asynchronous, active-high reset
- START  input  1  begin a test run; sampled only in IDLE
- DUT_Y  input  1  output of the gate under test
- DUT_A  output  1  gate input A (MSB of combination index)
- DUT_B  output  1  gate input B (LSB of combination index)
- BUSY  output  1  high while a run is in progress
- DONE  output  1  one-cycle pulse at end of run
- PASS  output  1  1 if the last run had no mismatches; held until the next START is accepted
- FAIL_MASK  output  4  bit i set if combination i mismatched
- CAPTURED  output  4  bit i = DUT_Y sampled for combination i

Behaviour:
- Reset: the asynchronous active-high RST forces all outputs and internal registers to 0 immediately.
  - Outputs: DUT_A, DUT_B, BUSY, DONE, PASS, FAIL_MASK, CAPTURED.
  - Internal registers: state = IDLE, idx = 0, settle counter = 0.
  - If RST is asserted mid-run, the run is aborted with no DONE; a new START is required after RST deasserts.
- All outputs are registered. States are IDLE, SETTLE and SAMPLE.
- IDLE:
  - DUT_A = DUT_B = 0, BUSY = 0.
  - If START = 1 at an edge (call it edge k0):
    - idx <= 0, {DUT_A, DUT_B} <= 00, counter <= 0.
    - BUSY <= 1, PASS <= 0, FAIL_MASK <= 0, CAPTURED <= 0.
    - state <= SETTLE.
- SETTLE: counter increments each cycle. At the edge where counter == SETTLE_CYCLES-1, state <= SAMPLE.
- SAMPLE (one cycle):
  - CAPTURED[idx] <= DUT_Y.
  - FAIL_MASK[idx] <= DUT_Y ^ EXPECT[idx].
  - If idx < 3: idx <= idx+1, {DUT_A, DUT_B} <= idx+1, counter <= 0, state <= SETTLE.
  - If idx == 3:
    - DONE <= 1.
    - PASS <= 1 if the 4-bit mismatch vector, including this cycle's bit, is zero; otherwise PASS <= 0.
    - BUSY <= 0, {DUT_A, DUT_B} <= 00, state <= IDLE.
- Timing:
  - Combination i is captured at edge k0 + (i+1)*(SETTLE_CYCLES+1).
  - DONE is high for exactly the one cycle after edge k0 + 4*(SETTLE_CYCLES+1). With the default, that is 12 cycles after START is accepted.
- START handling:
  - START is ignored while BUSY = 1, with no queuing.
  - START asserted during the DONE cycle (state is IDLE) is accepted. DONE still drops on the next edge, and PASS, FAIL_MASK and CAPTURED clear as for any accepted START.
- Result hold: FAIL_MASK, CAPTURED and PASS hold their values after DONE until the next accepted START or RST.
- DUT_Y must be stable by the sampling edge. The block performs no synchronisation; the DUT is combinational, in the same clock domain.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, SETTLE, SAMPLE)
  - NUM_COMBOS = 4
  - standard truth-table constants for the library gates: NOR_TT = 4'b0001, NAND_TT = 4'b0111, AND_TT = 4'b1000, OR_TT = 4'b1110, XOR_TT = 4'b0110
- One natural sub-module: settle_timer.
  - Loadable up-counter with clear and a terminal-count flag at SETTLE_CYCLES-1.
  - The FSM and result registers stay in the top module.

Test Plan:
- Reset, then pulse START, DUT = NOR model (Y = ~(A|B)), default parameters -> DONE 12 cycles after START is accepted; PASS = 1, FAIL_MASK = 0000, CAPTURED = 0001; DUT_A/DUT_B sequence 00, 01, 10, 11, changing every 3 cycles.
- DUT_Y stuck at 0 -> CAPTURED = 0000, FAIL_MASK = 0001, PASS = 0.
- DUT = OR model with EXPECT = NOR_TT -> CAPTURED = 1110, FAIL_MASK = 1111, PASS = 0.
- Extra START pulses at cycles 3 and 7 of a run -> ignored; exactly one DONE at cycle 12. A START during the DONE cycle -> new run begins, second DONE 12 cycles later.
- RST asserted during SETTLE of combination 1 (cycle 5) -> all outputs 0 asynchronously, before the next edge; no DONE. A subsequent START gives a normal run with PASS = 1.
- SETTLE_CYCLES = 5, EXPECT = NAND_TT, NAND DUT -> combinations captured at cycles 6, 12, 18, 24; DONE after cycle 24; PASS = 1, CAPTURED = 0111.
